// File: rtl/ifu_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package ifu_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 2;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

  // Fetch sequencer states: idle with a full buffer, a live request,
  // or a request whose response will be thrown away after a redirect.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } ifu_state_t;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO for prefetched instructions.
// The head entry is held in its own register so consumers never see a
// combinational path from the write data; flush wins over push.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int  DEPTH   = DEF_DEPTH,
  parameter type entry_t = ifu_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] count_n;
  logic             pop_ok;
  logic             push_ok;

  // Work out which operations actually take effect and the resulting pointers.
  always_comb begin
    pop_ok   = pop && (count != '0);
    push_ok  = push && ((count != CNT_W'(DEPTH)) || pop_ok);
    remain   = count - CNT_W'(pop_ok);
    count_n  = remain + CNT_W'(push_ok);
    rd_ptr_n = rd_ptr + PTR_W'(pop_ok);
  end

  // Entry storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head (head holds when emptied).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr + PTR_W'(push_ok);
      count  <= count_n;
      if (push_ok && (remain == '0)) begin
        head <= push_data;
      end else if (pop_ok && (remain != '0)) begin
        head <= mem[rd_ptr_n];
      end
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues word reads over a req/ack handshake,
// buffers the results and presents the oldest one as IR/ir_pc.
// Optional stall statistics counter is enabled with IFU_STALL_CNT_EN.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              ir_take,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  ifu_state_t        state;
  ifu_state_t        state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic [ADDR_W-1:0] drain_addr;
  logic              drain_load;
  logic              fifo_push;
  logic              fifo_flush;
  logic              take_eff;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_after_pop;
  entry_t            push_entry;
  entry_t            head_entry;

  // A pop only counts when something is there and no redirect is flushing it anyway.
  assign take_eff        = ir_take && ir_valid && !redirect;
  assign count_after_pop = fifo_count - CNT_W'(take_eff);
  assign push_entry      = '{pc: fetch_pc, instr: mem_rdata};

  ifu_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (proc_rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (take_eff),
    .flush     (fifo_flush),
    .head      (head_entry),
    .count     (fifo_count)
  );

  assign ir_valid = (fifo_count != '0);
  assign IR       = head_entry.instr;
  assign ir_pc    = head_entry.pc;

  // The request stays up in DRAIN on the old address until the stale response returns.
  assign mem_req  = (state == REQ) || (state == DRAIN);
  assign mem_addr = (state == DRAIN) ? drain_addr : fetch_pc;

  // Next-state, fetch address and buffer control; redirect outranks everything.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    drain_load    = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          fifo_flush    = 1'b1;
          fetch_pc_next = redirect_pc;
          state_next    = REQ;
        end else if (count_after_pop < CNT_W'(DEPTH)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fifo_flush    = 1'b1;
          fetch_pc_next = redirect_pc;
          if (mem_ack) begin
            state_next = REQ;
          end else begin
            drain_load = 1'b1;
            state_next = DRAIN;
          end
        end else if (mem_ack) begin
          fifo_push     = 1'b1;
          fetch_pc_next = fetch_pc + ADDR_W'(1);
          if (count_after_pop < CNT_W'(DEPTH - 1)) begin
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        if (redirect) begin
          fifo_flush    = 1'b1;
          fetch_pc_next = redirect_pc;
        end
        if (mem_ack) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, fetch PC and the address being drained.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (drain_load) begin
        drain_addr <= fetch_pc;
      end
    end
  end

`ifdef IFU_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles with nothing for the controller to decode.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      stall_q <= 16'h0000;
    end else if (!ir_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed, table-driven bench for ifu_prefetch.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        proc_rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_take;
  logic [15:0] IR;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] stall_cnt;

`ifdef IFU_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL10 = 16'd10;
`else
  localparam logic [15:0] EXP_STALL10 = 16'd0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ir_take;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        exp_req;
    logic        chk_addr;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_ir;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ifu_prefetch #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .DEPTH    (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .proc_rst    (proc_rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_take     (ir_take),
    .IR          (IR),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .stall_cnt   (stall_cnt)
  );

  function automatic void addVec(input logic rd, input logic [15:0] rpc, input logic tk,
                                 input logic ack, input logic [15:0] rdata, input logic req,
                                 input logic ca, input logic [15:0] addr, input logic vld,
                                 input logic [15:0] ir, input logic [15:0] pc);
    vec_t v;
    v.redirect = rd;  v.redirect_pc = rpc; v.ir_take = tk;
    v.mem_ack = ack;  v.mem_rdata = rdata; v.exp_req = req;
    v.chk_addr = ca;  v.exp_addr = addr;   v.exp_valid = vld;
    v.exp_ir = ir;    v.exp_pc = pc;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, and land 1 ns past the edge.
  task automatic applyStimulus(input vec_t v);
    redirect    = v.redirect;
    redirect_pc = v.redirect_pc;
    ir_take     = v.ir_take;
    mem_ack     = v.mem_ack;
    mem_rdata   = v.mem_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    ir_take     = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 16'h0000;
  endtask

  initial begin
    // rd  rpc      tk ack rdata     req ca addr     vld ir       pc
    addVec(0, 16'h0000, 0, 1, 16'h1234, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000); // 0 first request
    addVec(0, 16'h0000, 0, 1, 16'h1234, 1, 1, 16'h0001, 1, 16'h1234, 16'h0000); // 1 first data
    addVec(0, 16'h0000, 0, 1, 16'h5678, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000); // 2 full
    addVec(0, 16'h0000, 0, 1, 16'h5678, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000); // 3 stays full
    addVec(0, 16'h0000, 1, 1, 16'h5678, 1, 1, 16'h0002, 1, 16'h5678, 16'h0001); // 4 take reopens
    addVec(0, 16'h0000, 0, 1, 16'h9ABC, 0, 0, 16'h0000, 1, 16'h5678, 16'h0001); // 5 refill
    addVec(0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0003, 1, 16'h9ABC, 16'h0002); // 6
    addVec(0, 16'h0000, 1, 1, 16'h1111, 1, 1, 16'h0004, 1, 16'h1111, 16'h0003); // 7 take+ack
    addVec(0, 16'h0000, 1, 1, 16'h2222, 1, 1, 16'h0005, 1, 16'h2222, 16'h0004); // 8 streaming
    addVec(0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0005, 0, 16'h2222, 16'h0004); // 9 empty, IR holds
    addVec(0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0005, 0, 16'h2222, 16'h0004); // 10 take on empty
    addVec(0, 16'h0000, 0, 1, 16'h3333, 1, 1, 16'h0006, 1, 16'h3333, 16'h0005); // 11
    addVec(1, 16'h0040, 0, 0, 16'h0000, 1, 1, 16'h0006, 0, 16'h3333, 16'h0005); // 12 redirect, drain
    addVec(0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0006, 0, 16'h3333, 16'h0005); // 13
    addVec(0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0006, 0, 16'h3333, 16'h0005); // 14
    addVec(0, 16'h0000, 0, 1, 16'hDEAD, 1, 1, 16'h0040, 0, 16'h3333, 16'h0005); // 15 stale dropped
    addVec(0, 16'h0000, 0, 1, 16'h4444, 1, 1, 16'h0041, 1, 16'h4444, 16'h0040); // 16
    addVec(0, 16'h0000, 0, 1, 16'h5555, 0, 0, 16'h0000, 1, 16'h4444, 16'h0040); // 17 full
    addVec(1, 16'hFFFF, 1, 1, 16'h0000, 1, 1, 16'hFFFF, 0, 16'h4444, 16'h0040); // 18 redirect beats take
    addVec(0, 16'h0000, 1, 1, 16'h7777, 1, 1, 16'h0000, 1, 16'h7777, 16'hFFFF); // 19 wrap
    addVec(0, 16'h0000, 1, 1, 16'h8888, 1, 1, 16'h0001, 1, 16'h8888, 16'h0000); // 20
    addVec(1, 16'h0100, 0, 1, 16'hBAD0, 1, 1, 16'h0100, 0, 16'h8888, 16'h0000); // 21 redirect+ack
    addVec(0, 16'h0000, 0, 1, 16'h6666, 1, 1, 16'h0101, 1, 16'h6666, 16'h0100); // 22
    addVec(1, 16'h0200, 0, 0, 16'h0000, 1, 1, 16'h0101, 0, 16'h6666, 16'h0100); // 23 into drain
    addVec(1, 16'h0300, 0, 0, 16'h0000, 1, 1, 16'h0101, 0, 16'h6666, 16'h0100); // 24 redirect in drain
    addVec(0, 16'h0000, 0, 1, 16'hBAD1, 1, 1, 16'h0300, 0, 16'h6666, 16'h0100); // 25
    addVec(0, 16'h0000, 0, 1, 16'h3030, 1, 1, 16'h0301, 1, 16'h3030, 16'h0300); // 26

    idleInputs();
    proc_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset mem_req",   32'(mem_req),   32'h0);
    checkOutput("reset ir_valid",  32'(ir_valid),  32'h0);
    checkOutput("reset IR",        32'(IR),        32'h0);
    checkOutput("reset ir_pc",     32'(ir_pc),     32'h0);
    checkOutput("reset stall_cnt", 32'(stall_cnt), 32'h0);
    proc_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d mem_req", i),  32'(mem_req),  32'(vecs[i].exp_req));
      if (vecs[i].chk_addr)
        checkOutput($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("row%0d ir_valid", i), 32'(ir_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("row%0d IR", i),       32'(IR),       32'(vecs[i].exp_ir));
      checkOutput($sformatf("row%0d ir_pc", i),    32'(ir_pc),    32'(vecs[i].exp_pc));
    end

    // Reset in the middle of an outstanding request.
    idleInputs();
    proc_rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst mem_req",  32'(mem_req),  32'h0);
    checkOutput("midrst ir_valid", 32'(ir_valid), 32'h0);
    checkOutput("midrst IR",       32'(IR),       32'h0);
    proc_rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postrst mem_req",  32'(mem_req),  32'h1);
    checkOutput("postrst mem_addr", 32'(mem_addr), 32'h0);

    // Memory never answers for ten cycles after reset.
    proc_rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("stall reset", 32'(stall_cnt), 32'h0);
    proc_rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("stall ten",      32'(stall_cnt), 32'(EXP_STALL10));
    checkOutput("stall ir_valid", 32'(ir_valid),  32'h0);
    checkOutput("stall mem_addr", 32'(mem_addr),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
